// File: rtl/texture_pkg.sv
// Shared types for the texture upload path: RAM geometry, uploader states,
// error reasons and the per-texture descriptor layout.
package texture_pkg;

   localparam int ADDR_W = 17;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CHECK  = 2'd1,
      STREAM = 2'd2,
      COMMIT = 2'd3
   } upl_state_t;

   typedef enum logic [1:0] {
      ERR_BADTEX = 2'd0,
      ERR_EMPTY  = 2'd1,
      ERR_FULL   = 2'd2,
      ERR_DUP    = 2'd3
   } upl_err_t;

   typedef struct packed {
      logic [ADDR_W-1:0] base;
      logic [ADDR_W-1:0] len;
      logic              valid;
   } tex_desc_t;

endpackage

// File: rtl/texture_desc_table.sv
// Descriptor table: one entry per texture number, written at commit, read
// through a registered lookup port and probed combinationally for duplicates.
module texture_desc_table
   import texture_pkg::*;
#(
   parameter int MAX_TEX = 16
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      clear,
   input  logic      wr_en,
   input  logic [7:0] wr_idx,
   input  tex_desc_t wr_desc,
   input  logic [7:0] rd_idx,
   output tex_desc_t rd_desc,
   input  logic [7:0] probe_idx,
   output logic      probe_valid
);

   localparam int IDX_W = (MAX_TEX > 1) ? $clog2(MAX_TEX) : 1;

   tex_desc_t entries [MAX_TEX];

   function automatic logic in_range(input logic [7:0] idx);
      return 32'(idx) < MAX_TEX;
   endfunction

   assign probe_valid = in_range(probe_idx) && entries[probe_idx[IDX_W-1:0]].valid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < MAX_TEX; i++) entries[i] <= '0;
         rd_desc <= '0;
      end else begin
         if (clear) begin
            for (int i = 0; i < MAX_TEX; i++) entries[i] <= '0;
         end else if (wr_en && in_range(wr_idx)) begin
            entries[wr_idx[IDX_W-1:0]] <= wr_desc;
         end
         // Out-of-range lookups read as an all-zero, invalid descriptor.
         rd_desc <= in_range(rd_idx) ? entries[rd_idx[IDX_W-1:0]] : '0;
      end
   end

endmodule

// File: rtl/texture_uploader.sv
// Write-side master for the texture RAM: validates an upload request, streams
// words into contiguous storage and records the texture's descriptor.
module texture_uploader
   import texture_pkg::*;
#(
   parameter int MAX_TEX   = 16,
   parameter int MEM_DEPTH = 131072
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        tex_num,
   input  logic [ADDR_W-1:0] word_count,
   output logic              busy,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              write,
   output logic [ADDR_W-1:0] write_address,
   output logic [DATA_W-1:0] write_data,
   output logic              done,
   output logic              error,
   output logic [1:0]        err_code,
   input  logic              clear,
   input  logic [7:0]        lookup_tex,
   output logic [ADDR_W-1:0] lookup_base,
   output logic [ADDR_W-1:0] lookup_len,
   output logic              lookup_valid,
   output logic [1:0]        fsm_state
);

   localparam int PTR_W = ADDR_W + 1;
   localparam logic [PTR_W-1:0] DEPTH = PTR_W'(MEM_DEPTH);

   upl_state_t        state, state_next;
   logic [PTR_W-1:0]  alloc_ptr;
   logic [PTR_W-1:0]  alloc_end;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] remaining;
   logic [ADDR_W-1:0] cur_count;
   logic [7:0]        cur_tex;
   logic              check_fail;
   upl_err_t          check_code;
   logic              probe_valid;
   logic              handshake;
   tex_desc_t         commit_desc;
   tex_desc_t         lookup_desc;

   // Stream handshake: a word transfers on any cycle where in_valid and
   // in_ready are both high; in_ready is high only in STREAM.
   assign busy      = (state != IDLE);
   assign in_ready  = (state == STREAM);
   assign handshake = in_valid && in_ready;
   assign fsm_state = state;
   assign alloc_end = alloc_ptr + PTR_W'(word_count);

   // Evaluated against the live request so the error pulse lands in CHECK.
   always_comb begin
      check_fail = 1'b1;
      check_code = ERR_BADTEX;
      if (tex_num == 8'd0 || 32'(tex_num) >= MAX_TEX) check_code = ERR_BADTEX;
      else if (word_count == '0)                      check_code = ERR_EMPTY;
      else if (probe_valid)                           check_code = ERR_DUP;
      else if (alloc_end > DEPTH)                     check_code = ERR_FULL;
      else                                            check_fail = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (!clear && start) state_next = CHECK;
         CHECK:   state_next = error ? IDLE : STREAM;
         STREAM:  if (handshake && remaining == ADDR_W'(1)) state_next = COMMIT;
         COMMIT:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alloc_ptr     <= '0;
         wr_ptr        <= '0;
         remaining     <= '0;
         cur_count     <= '0;
         cur_tex       <= '0;
         write         <= 1'b0;
         write_address <= '0;
         write_data    <= '0;
         done          <= 1'b0;
         error         <= 1'b0;
         err_code      <= '0;
      end else begin
         write <= 1'b0;
         done  <= 1'b0;
         error <= 1'b0;
         case (state)
            IDLE: begin
               if (clear) begin
                  alloc_ptr <= '0;
               end else if (start) begin
                  cur_tex   <= tex_num;
                  cur_count <= word_count;
                  if (check_fail) begin
                     error    <= 1'b1;
                     err_code <= check_code;
                  end
               end
            end
            CHECK: begin
               if (!error) begin
                  wr_ptr    <= alloc_ptr[ADDR_W-1:0];
                  remaining <= cur_count;
               end
            end
            STREAM: begin
               if (handshake) begin
                  write         <= 1'b1;
                  write_address <= wr_ptr;
                  write_data    <= in_data;
                  wr_ptr        <= wr_ptr + 1'b1;
                  remaining     <= remaining - 1'b1;
                  if (remaining == ADDR_W'(1)) done <= 1'b1;
               end
            end
            COMMIT: alloc_ptr <= alloc_ptr + PTR_W'(cur_count);
            default: ;
         endcase
      end
   end

   assign commit_desc = '{base: alloc_ptr[ADDR_W-1:0], len: cur_count, valid: 1'b1};

   texture_desc_table #(.MAX_TEX(MAX_TEX)) u_table (
      .clk         (clk),
      .reset       (reset),
      .clear       (state == IDLE && clear),
      .wr_en       (state == COMMIT),
      .wr_idx      (cur_tex),
      .wr_desc     (commit_desc),
      .rd_idx      (lookup_tex),
      .rd_desc     (lookup_desc),
      .probe_idx   (tex_num),
      .probe_valid (probe_valid)
   );

   assign lookup_base  = lookup_desc.base;
   assign lookup_len   = lookup_desc.len;
   assign lookup_valid = lookup_desc.valid;

endmodule

// File: tb/tb_texture_uploader.sv
// Self-checking bench for texture_uploader: scenario tasks drive requests and
// pixel streams, a write monitor pops expected beats from a queue.
module tb_texture_uploader;

   localparam int AW    = 17;
   localparam int DW    = 32;
   localparam int DEPTH = 256;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [7:0]    tex_num = '0;
   logic [AW-1:0] word_count = '0;
   logic          busy;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready;
   logic          write;
   logic [AW-1:0] write_address;
   logic [DW-1:0] write_data;
   logic          done;
   logic          error;
   logic [1:0]    err_code;
   logic          clear = 1'b0;
   logic [7:0]    lookup_tex = '0;
   logic [AW-1:0] lookup_base;
   logic [AW-1:0] lookup_len;
   logic          lookup_valid;
   logic [1:0]    fsm_state;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int wr_count = 0;
   int model_alloc = 0;
   logic [AW+DW-1:0] exp_q[$];
   logic [AW+DW-1:0] mon_e;

   // Small RAM depth keeps the capacity-boundary uploads short.
   texture_uploader #(.MAX_TEX(16), .MEM_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .start(start), .tex_num(tex_num),
      .word_count(word_count), .busy(busy), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready), .write(write),
      .write_address(write_address), .write_data(write_data), .done(done),
      .error(error), .err_code(err_code), .clear(clear),
      .lookup_tex(lookup_tex), .lookup_base(lookup_base),
      .lookup_len(lookup_len), .lookup_valid(lookup_valid),
      .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   always @(negedge clk) begin
      if (reset && write) begin
         wr_count++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", write_address, write_data);
         end else begin
            mon_e = exp_q.pop_front();
            if ({write_address, write_data} !== mon_e) begin
               bad++;
               $display("FAIL write_beat: got addr=%0d data=%h, expected addr=%0d data=%h",
                        write_address, write_data, mon_e[AW+DW-1:DW], mon_e[DW-1:0]);
            end
         end
      end
   end

   task automatic check_lookup(input logic [7:0] tex, input logic v, input int b, input int l);
      lookup_tex = tex;
      @(posedge clk); #1;
      total++;
      if ({lookup_valid, lookup_base, lookup_len} !== {v, AW'(b), AW'(l)}) begin
         bad++;
         $display("FAIL lookup_%0d: got v=%0b base=%0d len=%0d, expected v=%0b base=%0d len=%0d",
                  tex, lookup_valid, lookup_base, lookup_len, v, b, l);
      end
   endtask

   task automatic do_upload(input logic [7:0] tex, input int n, input logic [31:0] pat,
                            input bit gaps, input int poke_at, input int abort_after);
      int c0, w, wr0, exp_lat, base;
      base = model_alloc;
      c0 = cyc;
      start = 1'b1; tex_num = tex; word_count = AW'(n);
      @(posedge clk); #1;
      start = 1'b0;
      total++;
      if (busy !== 1'b1 || in_ready !== 1'b0 || fsm_state !== 2'd1) begin
         bad++;
         $display("FAIL check_cycle: got busy=%0b in_ready=%0b state=%0d, expected 1 0 1", busy, in_ready, fsm_state);
      end
      w = 0;
      while (in_ready !== 1'b1 && w < 4) begin
         @(posedge clk); #1;
         w++;
      end
      total++;
      if (in_ready !== 1'b1 || cyc - c0 != 2) begin
         bad++;
         $display("FAIL first_ready: got in_ready=%0b after %0d cycles, expected 1 after 2", in_ready, cyc - c0);
         in_valid = 1'b0;
         return;
      end
      wr0 = wr_count;
      for (int i = 0; i < n; i++) begin
         if (abort_after > 0 && i == abort_after) begin
            reset = 1'b0;
            #1;
            total++;
            if ({busy, in_ready, write, done, error, lookup_valid} !== 6'b0 || write_address !== '0 ||
                write_data !== '0 || err_code !== 2'd0 || lookup_base !== '0 || lookup_len !== '0 ||
                fsm_state !== 2'd0) begin
               bad++;
               $display("FAIL reset_abort: got busy=%0b rdy=%0b wr=%0b addr=%0d data=%h err_code=%0d lv=%0b, expected all 0",
                        busy, in_ready, write, write_address, write_data, err_code, lookup_valid);
            end
            in_valid = 1'b0;
            exp_q.delete();
            model_alloc = 0;
            return;
         end
         if (gaps && i > 0) begin
            in_valid = 1'b0; in_data = 32'hDEADBEEF;
            @(posedge clk); #1;
         end
         in_valid = 1'b1; in_data = pat;
         exp_q.push_back({AW'(base + i), pat});
         if (i == poke_at) begin
            start = 1'b1; tex_num = 8'd7; word_count = AW'(3);
         end
         @(posedge clk); #1;
         start = 1'b0;
      end
      in_valid = 1'b0;
      exp_lat = n + 2 + (gaps ? n - 1 : 0);
      total++;
      if (done !== 1'b1 || busy !== 1'b1 || cyc - c0 != exp_lat) begin
         bad++;
         $display("FAIL done_timing: got done=%0b busy=%0b at cycle %0d, expected 1 1 at %0d", done, busy, cyc - c0, exp_lat);
      end
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL return_idle: got done=%0b busy=%0b, expected 0 0", done, busy);
      end
      total++;
      if (wr_count - wr0 != n || exp_q.size() != 0) begin
         bad++;
         $display("FAIL write_count: got %0d writes (%0d pending), expected %0d", wr_count - wr0, exp_q.size(), n);
      end
      model_alloc = base + n;
   endtask

   task automatic try_error(input logic [7:0] tex, input int cnt, input logic [1:0] code);
      int wr0;
      wr0 = wr_count;
      start = 1'b1; tex_num = tex; word_count = AW'(cnt);
      @(posedge clk); #1;
      start = 1'b0;
      total++;
      if (error !== 1'b1 || err_code !== code || busy !== 1'b1) begin
         bad++;
         $display("FAIL err_pulse_t%0d_c%0d: got error=%0b code=%0d busy=%0b, expected 1 %0d 1", tex, cnt, error, err_code, busy, code);
      end
      @(posedge clk); #1;
      total++;
      if (error !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || err_code !== code || wr_count != wr0) begin
         bad++;
         $display("FAIL err_after_t%0d: got error=%0b busy=%0b rdy=%0b code=%0d writes=%0d, expected 0 0 0 %0d 0",
                  tex, error, busy, in_ready, err_code, wr_count - wr0, code);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({busy, in_ready, write, done, error, lookup_valid} !== 6'b0 || write_address !== '0 ||
          write_data !== '0 || err_code !== 2'd0 || lookup_base !== '0 || lookup_len !== '0 || fsm_state !== 2'd0) begin
         bad++;
         $display("FAIL reset_values: got busy=%0b rdy=%0b wr=%0b done=%0b err=%0b lv=%0b, expected all 0",
                  busy, in_ready, write, done, error, lookup_valid);
      end
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_uploads();
      do_upload(8'd1, 50, 32'hFFFFFFFF, 1'b0, -1, 0);
      check_lookup(8'd1, 1'b1, 0, 50);
      do_upload(8'd2, 30, 32'hFF000000, 1'b1, -1, 0);
      check_lookup(8'd2, 1'b1, 50, 30);
      do_upload(8'd3, 40, 32'h00FF0000, 1'b0, -1, 0);
      check_lookup(8'd3, 1'b1, 80, 40);
   endtask

   task automatic test_errors();
      try_error(8'd0, 5, 2'd0);
      try_error(8'd16, 5, 2'd0);
      try_error(8'd0, 0, 2'd0);
      try_error(8'd2, 0, 2'd1);
      try_error(8'd2, 5, 2'd3);
      try_error(8'd4, 0, 2'd1);
      try_error(8'd4, DEPTH - 119, 2'd2);
      check_lookup(8'd4, 1'b0, 0, 0);
      do_upload(8'd4, DEPTH - 120, 32'h0000FF00, 1'b0, -1, 0);
      check_lookup(8'd4, 1'b1, 120, DEPTH - 120);
      try_error(8'd5, 1, 2'd2);
      check_lookup(8'd16, 1'b0, 0, 0);
      check_lookup(8'd200, 1'b0, 0, 0);
   endtask

   task automatic test_clear_start();
      clear = 1'b1; start = 1'b1; tex_num = 8'd9; word_count = AW'(4);
      @(posedge clk); #1;
      clear = 1'b0; start = 1'b0;
      total++;
      if (busy !== 1'b0 || error !== 1'b0) begin
         bad++;
         $display("FAIL clear_start: got busy=%0b error=%0b, expected 0 0", busy, error);
      end
      model_alloc = 0;
      check_lookup(8'd1, 1'b0, 0, 0);
      check_lookup(8'd4, 1'b0, 0, 0);
      do_upload(8'd1, 5, 32'h000000FF, 1'b0, -1, 0);
      check_lookup(8'd1, 1'b1, 0, 5);
   endtask

   task automatic test_start_in_stream();
      do_upload(8'd2, 20, 32'h12345678, 1'b0, 5, 0);
      check_lookup(8'd7, 1'b0, 0, 0);
      check_lookup(8'd2, 1'b1, 5, 20);
   endtask

   task automatic test_reset_mid();
      check_lookup(8'd1, 1'b1, 0, 5);
      do_upload(8'd3, 50, 32'hA5A5A5A5, 1'b0, -1, 10);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      do_upload(8'd1, 8, 32'h5A5A5A5A, 1'b0, -1, 0);
      check_lookup(8'd1, 1'b1, 0, 8);
      check_lookup(8'd2, 1'b0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_uploads();
      test_errors();
      test_clear_start();
      test_start_in_stream();
      test_reset_mid();
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
